// File: rtl/display_access_scheduler_pkg.sv
// Shared constants and helpers for the board seven-segment/LED display blocks.
package display_access_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    typedef enum logic {
        SLOT_ADDR = 1'b0,
        SLOT_DATA = 1'b1
    } slot_e;

    localparam logic [3:0] ANODE_ADDR = 4'b1011;
    localparam logic [3:0] ANODE_DATA = 4'b1101;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [6:0] SEG_DEFAULT = 7'h36;

    localparam logic [1:0] LED_RW_NONE  = 2'b00;
    localparam logic [1:0] LED_RW_READ  = 2'b01;
    localparam logic [1:0] LED_RW_WRITE = 2'b10;

    localparam logic [1:0] LED_RES_NONE = 2'b00;
    localparam logic [1:0] LED_RES_OK   = 2'b01;
    localparam logic [1:0] LED_RES_FAIL = 2'b10;

    // Active-low hex font, segments g..a.
    function automatic logic [6:0] hex_font(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = SEG_DEFAULT;
        endcase
        return s;
    endfunction

    // Any fail code (1x) collapses onto the single fail LED.
    function automatic logic [1:0] result_led(input logic [1:0] r);
        logic [1:0] l;
        case (r)
            2'b00:   l = LED_RES_NONE;
            2'b01:   l = LED_RES_OK;
            default: l = LED_RES_FAIL;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/display_access_scheduler_hex.sv
// Hex digit to active-low seven-segment pattern.
module hex7seg_decoder
    import display_access_scheduler_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Pure table lookup into the shared font.
    always_comb begin
        seg = hex_font(code);
    end

endmodule

// File: rtl/display_access_scheduler.sv
// Accepts one memory-access report at a time and holds it on the two-digit
// display (address / data multiplexed) plus status LEDs for a fixed time.
module display_access_scheduler
    import display_access_scheduler_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned HOLD_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [3:0] req_addr,
    input  logic [3:0] req_data,
    input  logic [1:0] req_result,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] led_rw,
    output logic [1:0] led_result
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(HOLD_FRAMES);

    state_e            state_q, state_d;
    slot_e             slot_q, slot_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              ready_q, ready_d;

    logic              wr_q;
    logic [3:0]        addr_q, data_q;
    logic [1:0]        res_q;

    logic [3:0]        anode_q, anode_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [1:0]        led_rw_q, led_rw_d;
    logic [1:0]        led_res_q, led_res_d;

    logic              accept;
    logic [3:0]        digit_code;
    logic [6:0]        font_seg;

    assign accept     = req_valid && ready_q;
    assign digit_code = (slot_q == SLOT_ADDR) ? addr_q : data_q;

    hex7seg_decoder u_font (
        .code (digit_code),
        .seg  (font_seg)
    );

    // FSM, scan and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            slot_q  <= SLOT_ADDR;
            scan_q  <= '0;
            hold_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            scan_q  <= scan_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
        end
    end

    // Next state: accept restarts the hold, otherwise scan and count frames.
    // Ready is derived from the next state so it rises on the very edge the
    // last frame completes.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        scan_d  = scan_q;
        hold_d  = hold_q;
        if (accept) begin
            state_d = ST_SHOW;
            slot_d  = SLOT_ADDR;
            scan_d  = '0;
            hold_d  = '0;
        end else if (state_q != ST_BLANK) begin
            if (scan_q == SCAN_LAST) begin
                scan_d = '0;
                slot_d = (slot_q == SLOT_ADDR) ? SLOT_DATA : SLOT_ADDR;
                if (state_q == ST_SHOW && slot_q == SLOT_DATA) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_d == HOLD_DONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end else begin
                scan_d = scan_q + 1'b1;
            end
        end
        ready_d = (state_d != ST_SHOW);
    end

    // Latch the accepted report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            res_q  <= '0;
        end else if (accept) begin
            wr_q   <= req_write;
            addr_q <= req_addr;
            data_q <= req_data;
            res_q  <= req_result;
        end
    end

    // Display/LED values from current state; registered one cycle later.
    always_comb begin
        anode_d   = ANODE_OFF;
        seg_d     = SEG_BLANK;
        dp_d      = 1'b1;
        led_rw_d  = LED_RW_NONE;
        led_res_d = LED_RES_NONE;
        if (state_q != ST_BLANK) begin
            seg_d     = font_seg;
            led_rw_d  = wr_q ? LED_RW_WRITE : LED_RW_READ;
            led_res_d = result_led(res_q);
            if (slot_q == SLOT_ADDR) begin
                anode_d = ANODE_ADDR;
            end else begin
                anode_d = ANODE_DATA;
                dp_d    = ~wr_q;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_q   <= ANODE_OFF;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            led_rw_q  <= LED_RW_NONE;
            led_res_q <= LED_RES_NONE;
        end else begin
            anode_q   <= anode_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            led_rw_q  <= led_rw_d;
            led_res_q <= led_res_d;
        end
    end

    assign req_ready  = ready_q;
    assign anode      = anode_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign led_rw     = led_rw_q;
    assign led_result = led_res_q;

endmodule

// File: tb/tb_display_access_scheduler.sv
// Directed bench for display_access_scheduler with SCAN_DIV=4, HOLD_FRAMES=2.
module tb_display_access_scheduler;

    localparam int unsigned SCAN_DIV    = 4;
    localparam int unsigned HOLD_FRAMES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [3:0] req_data;
    logic [1:0] req_result;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] led_rw;
    logic [1:0] led_result;

    display_access_scheduler #(
        .SCAN_DIV    (SCAN_DIV),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_result (req_result),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .led_rw     (led_rw),
        .led_result (led_result)
    );

    always #5 clk = ~clk;

    // Observation vector: {ready, anode[3:0], seg[6:0], dp, led_rw[1:0], led_result[1:0]}
    typedef struct {
        logic        valid;
        logic        write;
        logic [3:0]  addr;
        logic [3:0]  data;
        logic [1:0]  result;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_bad    = 0;

    function automatic logic [16:0] mk(input logic r, input logic [3:0] an, input logic [6:0] sg,
                                       input logic d, input logic [1:0] rw, input logic [1:0] rs);
        return {r, an, sg, d, rw, rs};
    endfunction

    function automatic logic [16:0] dark(input logic r);
        return mk(r, 4'b1111, 7'h7F, 1'b1, 2'b00, 2'b00);
    endfunction

    function automatic logic [16:0] obs();
        return {req_ready, anode, seg, dp, led_rw, led_result};
    endfunction

    function automatic void add(input logic v, input logic w, input logic [3:0] a, input logic [3:0] d,
                                input logic [1:0] r, input logic [16:0] e);
        vec_t x;
        x.valid = v; x.write = w; x.addr = a; x.data = d; x.result = r; x.exp = e;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b an=%b seg=%h dp=%b rw=%b res=%b, want rdy=%b an=%b seg=%h dp=%b rw=%b res=%b",
                     name, act[16], act[15:12], act[11:5], act[4], act[3:2], act[1:0],
                     exp[16], exp[15:12], exp[11:5], exp[4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [3:0] a, input logic [3:0] d,
                         input logic [1:0] r);
        req_valid = v; req_write = w; req_addr = a; req_data = d; req_result = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Table: idle after reset, a write held 16 cycles, then a read with fail.
        add(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, dark(1'b1));
        add(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, dark(1'b1));
        add(1'b1, 1'b1, 4'hA, 4'h3, 2'b01, dark(1'b0));
        for (int i = 0; i < 16; i++) begin
            if (((i / 4) % 2) == 1)
                add(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, mk(i == 15, 4'b1101, 7'h30, 1'b0, 2'b10, 2'b01));
            else
                add(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, mk(i == 15, 4'b1011, 7'h08, 1'b1, 2'b10, 2'b01));
        end
        add(1'b1, 1'b0, 4'h0, 4'hF, 2'b11, mk(1'b0, 4'b1011, 7'h08, 1'b1, 2'b10, 2'b01));
        for (int i = 0; i < 16; i++) begin
            if (((i / 4) % 2) == 1)
                add(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, mk(i == 15, 4'b1101, 7'h0E, 1'b1, 2'b01, 2'b10));
            else
                add(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, mk(i == 15, 4'b1011, 7'h40, 1'b1, 2'b01, 2'b10));
        end
        for (int i = 0; i < 4; i++)
            add(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, mk(1'b1, 4'b1011, 7'h40, 1'b1, 2'b01, 2'b10));
        add(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, mk(1'b1, 4'b1101, 7'h0E, 1'b1, 2'b01, 2'b10));

        drive(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_async", obs(), dark(1'b0));
        repeat (5) @(posedge clk);
        #1 check("reset_held", obs(), dark(1'b0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].data, vecs[i].result);
            step();
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Second report arrives during SHOW and is held until ready is seen high.
        drive(1'b1, 1'b1, 4'h5, 4'h6, 2'b01);
        step();
        check("b2b_accept", obs(), mk(1'b0, 4'b1101, 7'h0E, 1'b1, 2'b01, 2'b10));
        drive(1'b1, 1'b0, 4'h7, 4'h9, 2'b10);
        for (int i = 1; i <= 16; i++) begin
            step();
            if ((((i - 1) / 4) % 2) == 1)
                check($sformatf("b2b_hold%0d", i), obs(), mk(i == 16, 4'b1101, 7'h02, 1'b0, 2'b10, 2'b01));
            else
                check($sformatf("b2b_hold%0d", i), obs(), mk(i == 16, 4'b1011, 7'h12, 1'b1, 2'b10, 2'b01));
        end
        step();
        check("b2b_second_accept", obs(), mk(1'b0, 4'b1011, 7'h12, 1'b1, 2'b10, 2'b01));
        drive(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
        step();
        check("b2b_second_shown", obs(), mk(1'b0, 4'b1011, 7'h78, 1'b1, 2'b01, 2'b10));

        // Asynchronous reset at cycle 7 of the hold.
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1 check("reset_mid_show", obs(), dark(1'b0));
        step();
        step();
        check("reset_mid_hold", obs(), dark(1'b0));
        rst_n = 1'b1;

        // Valid present at release: ignored on the first edge, accepted on the second.
        drive(1'b1, 1'b0, 4'hF, 4'h0, 2'b00);
        step();
        check("post_reset_ready", obs(), dark(1'b1));
        step();
        check("post_reset_accept", obs(), dark(1'b0));
        drive(1'b0, 1'b0, 4'h0, 4'h0, 2'b00);
        step();
        check("post_reset_addr", obs(), mk(1'b0, 4'b1011, 7'h0E, 1'b1, 2'b01, 2'b00));
        repeat (4) step();
        check("post_reset_data", obs(), mk(1'b0, 4'b1101, 7'h40, 1'b1, 2'b01, 2'b00));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
